// File: rtl/fifo_pkg.sv
// Shared widths for the 16-bit-in / 4-bit-out FIFO.
package fifo_pkg;

    localparam int DIN_W  = 16;
    localparam int DOUT_W = 4;
    localparam int RATIO  = DIN_W / DOUT_W;
    localparam int NIB_W  = $clog2(RATIO);

    // Pick nibble idx out of a stored word, LSB nibble first.
    function automatic logic [DOUT_W-1:0] nib_sel(input logic [DIN_W-1:0] word,
                                                 input logic [NIB_W-1:0] idx);
        return word[idx*DOUT_W +: DOUT_W];
    endfunction

endpackage

// File: rtl/fifo_big2small_sdp_ram.sv
// Simple dual-port storage: sync write, sync read with a resettable read register.
module sdp_ram
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DIN_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [DIN_W-1:0] rdata
);

    logic [DIN_W-1:0] mem [DEPTH];
    logic [DIN_W-1:0] rdata_q;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register only loads on an accepted read, so the output holds otherwise.
    always_ff @(posedge clk) begin
        if (rst)     rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_big2small.sv
// Word-wide write, nibble-wide read FIFO. A word slot frees after its 4th nibble.
module fifo_big2small
    import fifo_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int PROG_FULL_TH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_en,
    output logic              full,
    output logic              prog_full,
    input  logic              dout_req,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_en,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic [NIB_W-1:0] sel_q;
    logic             dout_en_q;
    logic             wr_acc, rd_acc, free;
    logic [DIN_W-1:0] rdata;

    // Flags decode straight from the registered count.
    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign prog_full = (cnt_q >= (AW+1)'(PROG_FULL_TH));
    assign empty     = (cnt_q == '0);

    assign wr_acc = din_en & ~full;
    assign rd_acc = dout_req & ~empty;
    assign free   = rd_acc & (nib_q == NIB_W'(RATIO-1));

    // Next-state for pointers, nibble index and word count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        nib_d    = nib_q;
        cnt_d    = cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) nib_d    = nib_q + 1'b1;
        if (free)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, free})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State and output-select registers; sel_q pairs with the RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            nib_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            dout_en_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            nib_q     <= nib_d;
            cnt_q     <= cnt_d;
            dout_en_q <= rd_acc;
            if (rd_acc) sel_q <= nib_q;
        end
    end

    sdp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Both sources are registers that only move on a read, so dout holds between reads.
    assign dout    = nib_sel(rdata, sel_q);
    assign dout_en = dout_en_q;

endmodule

// File: tb/tb_fifo_big2small.sv
// Scoreboard bench: expected nibbles queued on accepted writes, popped on dout_en.
module tb_fifo_big2small;

    localparam int DEPTH = 8;
    localparam int PFT   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_en;
    logic        full, prog_full, empty;
    logic        dout_req;
    logic [3:0]  dout;
    logic        dout_en;

    int          n_chk = 0;
    int          n_pass = 0;
    int          mcnt = 0;
    int          mnib = 0;
    int          nout = 0;
    logic [3:0]  mdout = 4'h0;
    logic [3:0]  sb[$];

    always #5 clk = ~clk;

    fifo_big2small #(.DEPTH(DEPTH), .PROG_FULL_TH(PFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .full      (full),
        .prog_full (prog_full),
        .dout_req  (dout_req),
        .dout      (dout),
        .dout_en   (dout_en),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: model the edge from current inputs, then compare just after it.
    task automatic tick();
        bit wacc, racc, fr, exp_en;
        wacc   = din_en && (mcnt < DEPTH);
        racc   = dout_req && (mcnt > 0);
        exp_en = 1'b0;
        fr     = 1'b0;
        if (rst) begin
            sb.delete();
            mcnt  = 0;
            mnib  = 0;
            mdout = 4'h0;
        end else begin
            if (racc) begin
                exp_en = 1'b1;
                if (sb.size() > 0) mdout = sb.pop_front();
                mnib++;
                if (mnib == 4) begin
                    mnib = 0;
                    fr   = 1'b1;
                end
            end
            if (wacc)
                for (int i = 0; i < 4; i++) sb.push_back(din[i*4 +: 4]);
            mcnt = mcnt + int'(wacc) - int'(fr);
        end
        @(posedge clk);
        #1;
        chk("dout_en", 32'(dout_en), 32'(exp_en));
        chk("dout", 32'(dout), 32'(mdout));
        chk("empty", 32'(empty), 32'(mcnt == 0));
        chk("full", 32'(full), 32'(mcnt == DEPTH));
        chk("prog_full", 32'(prog_full), 32'(mcnt >= PFT));
        if (dout_en) nout++;
    endtask

    task automatic idle(input int n);
        din_en   = 1'b0;
        dout_req = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [15:0] w, input logic rq);
        din      = w;
        din_en   = 1'b1;
        dout_req = rq;
        tick();
        din_en   = 1'b0;
    endtask

    task automatic drain(input int max);
        din_en   = 1'b0;
        dout_req = 1'b1;
        for (int i = 0; i < max && mcnt > 0; i++) tick();
        dout_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; din = '0; din_en = 1'b0; dout_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);

        // In-order unpacking
        wr(16'h4321, 1'b0);
        wr(16'h8765, 1'b0);
        nout = 0;
        drain(20);
        chk("unpack_n", 32'(nout), 32'd8);
        chk("unpack_empty", 32'(empty), 32'd1);

        // Fill and overflow
        for (int i = 0; i < 10; i++) begin
            wr(16'(i), 1'b0);
            if (i == 5) chk("pf_after6", 32'(prog_full), 32'd1);
            if (i == 6) chk("full_before8", 32'(full), 32'd0);
            if (i == 7) chk("full_after8", 32'(full), 32'd1);
        end
        nout = 0;
        drain(60);
        chk("ovf_drain_n", 32'(nout), 32'd32);

        // Underflow
        nout = 0;
        din_en = 1'b0; dout_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        dout_req = 1'b0;
        chk("udf_n", 32'(nout), 32'd0);
        chk("udf_empty", 32'(empty), 32'd1);

        // Simultaneous traffic
        for (int w = 0; w < 50; w++) begin
            wr(16'($urandom), 1'b1);
            dout_req = 1'b1;
            for (int c = 0; c < 3; c++) tick();
        end
        drain(20);

        // Reset mid-stream
        wr(16'hABCD, 1'b0);
        dout_req = 1'b1; tick(); tick();
        dout_req = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_dout", 32'(dout), 32'd0);
        wr(16'h1234, 1'b0);
        nout = 0;
        drain(10);
        chk("mrst_n", 32'(nout), 32'd4);

        // Wrap-around at fill level 5
        for (int i = 0; i < 5; i++) wr(16'($urandom), 1'b0);
        for (int w = 0; w < 3*DEPTH; w++) begin
            wr(16'($urandom), 1'b1);
            dout_req = 1'b1;
            for (int c = 0; c < 3; c++) tick();
        end
        drain(40);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_big2small.md
FIFO_BIG2SMALL -- requirements
Module: fifo_big2small

Interface
REQ-001 SHALL have parameter DEPTH, default 8, storage depth in 16-bit words (power of two, >=4).
REQ-002 SHALL have parameter PROG_FULL_TH, default 6, word count at or above which prog_full asserts.
REQ-003 SHALL have port clk  input  1  single clock for all logic; rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  16  write word.
REQ-006 SHALL have port din_en  input  1  write strobe, one word per cycle.
REQ-007 SHALL have port full  output  1  no free word slot.
REQ-008 SHALL have port prog_full  output  1  word count >= PROG_FULL_TH.
REQ-009 SHALL have port dout_req  input  1  read request, one nibble per cycle.
REQ-010 SHALL have port dout  output  4  read nibble.
REQ-011 SHALL have port dout_en  output  1  dout valid, single-cycle pulse per nibble.
REQ-012 SHALL have port empty  output  1  no unread nibble held.

Function
REQ-013 SHALL accept a write when din_en=1 and full=0, storing din at the write pointer, then incrementing it modulo DEPTH.
REQ-014 SHALL silently drop a write when din_en=1 and full=1, with no state change.
REQ-015 SHALL emit nibbles LSB first: din[3:0], [7:4], [11:8], [15:12].
REQ-016 SHALL accept a read when dout_req=1 and empty=0; dout/dout_en SHALL appear the cycle after acceptance (latency 1).
REQ-017 SHALL ignore dout_req while empty=1: dout_en=0, dout holds its last value.
REQ-018 SHALL hold a 2-bit nibble index; a word slot SHALL be freed only when nibble 3 is read, which also resets the index to 0 and advances the read pointer modulo DEPTH.
REQ-019 SHALL keep a word count 0..DEPTH, one bit wider than the pointers; count +1 on accepted write, -1 on word-free, unchanged when both occur in one cycle.
REQ-020 SHALL decode full=(count==DEPTH), prog_full=(count>=PROG_FULL_TH) and empty=(count==0) from registered state, so the flags are valid in the cycle after the causing event.
REQ-021 SHALL, when a write and a word-freeing read are both accepted at count==DEPTH-1, end at count==DEPTH-1.
REQ-022 SHALL use full as registered at the clock edge; a same-cycle word-free SHALL NOT admit a write while full=1.
REQ-023 SHALL wrap both pointers from DEPTH-1 to 0 with no lost or duplicated data.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear the pointers, nibble index and count to 0 and drive dout=4'h0, dout_en=0, empty=1, full=0, prog_full=0.
REQ-025 SHALL, when reset arrives mid-operation, discard all held data; the cycle after rst deasserts SHALL accept writes, and dout_en SHALL stay 0 until new data is read.
REQ-026 SHALL NOT clear storage contents on reset.

Structure
REQ-027 SHALL take DIN_W=16, DOUT_W=4, RATIO=4 and the nibble index width from the shared fifo_pkg package.
REQ-028 SHALL place storage in one sub-module, sdp_ram: simple dual-port, DEPTH x 16, synchronous write, synchronous read.
REQ-029 SHALL place the pointers, count, nibble index, flags and output registers in fifo_big2small.

Verification
REQ-030 SHALL test in-order unpacking: write 16'h4321 then 16'h8765, then hold dout_req=1 -> dout 1,2,3,4,5,6,7,8 on consecutive dout_en cycles, then empty=1.
REQ-031 SHALL test fill and overflow: with dout_req=0, write 10 words 16'h0000..16'h0009 -> prog_full rises after the 6th, full after the 8th; words 8 and 9 are dropped; draining returns exactly 32 nibbles from words 0..7.
REQ-032 SHALL test underflow: pulse dout_req for 3 cycles while empty -> dout_en stays 0 and count stays 0.
REQ-033 SHALL test simultaneous traffic: one write every 4 cycles plus continuous dout_req, 50 random words -> output matches the scoreboard, full never asserts, and no underflow appears after the first word.
REQ-034 SHALL test reset mid-stream: assert rst for 1 cycle after 2 nibbles of 16'hABCD -> empty=1, dout=0; a following write of 16'h1234 reads back as 4,3,2,1.
REQ-035 SHALL test wrap-around: 3xDEPTH words through the FIFO at fill level 5 -> data integrity holds across the pointer wrap.
